// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared fetch-pipeline defaults and the next-PC select encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int unsigned  XLEN_DEF     = 32;
   localparam logic [31:0]  RESET_PC_DEF = 32'h0000_0000;
   localparam int unsigned  PC_INC_DEF   = 4;

   // Encoded in priority order, oldest redirect first
   typedef enum logic [2:0] {
      SEL_EX   = 3'd0,
      SEL_ID   = 3'd1,
      SEL_HOLD = 3'd2,
      SEL_PRED = 3'd3,
      SEL_SEQ  = 3'd4
   } npc_sel_e;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/btb_dm.sv
// ============================================================================
// Module : btb_dm
// Brief  : Direct-mapped branch target buffer; one combinational read port,
//          two write ports (EX has priority over ID on an index collision).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btb_dm
   import pipe_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEF,
   parameter int unsigned BTB_IDX = 3
) (
   input  logic            clk,
   input  logic            rst,
   // lookup
   input  logic [XLEN-1:0] rd_pc_i,
   output logic            hit_o,
   output logic [XLEN-1:0] target_o,
   // EX port: install on taken, invalidate a matching entry on not-taken
   input  logic            ex_we_i,
   input  logic            ex_clr_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [XLEN-1:0] ex_target_i,
   // ID port: install jal
   input  logic            id_we_i,
   input  logic [XLEN-1:0] id_pc_i,
   input  logic [XLEN-1:0] id_target_i
);

   localparam int unsigned DEPTH = 2 ** BTB_IDX;
   localparam int unsigned TAGW  = XLEN - BTB_IDX - 2;

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [TAGW-1:0]  tag_q [DEPTH];
   logic [XLEN-1:0]  tgt_q [DEPTH];

   logic [BTB_IDX-1:0] w_rd_idx;
   logic [BTB_IDX-1:0] w_ex_idx;
   logic [BTB_IDX-1:0] w_id_idx;
   logic [TAGW-1:0]    w_rd_tag;
   logic [TAGW-1:0]    w_ex_tag;
   logic [TAGW-1:0]    w_id_tag;
   logic               w_ex_clr;
   logic               w_ex_act;
   logic               w_id_act;
   logic               w_unused;

   assign w_rd_idx = rd_pc_i[BTB_IDX+1:2];
   assign w_ex_idx = ex_pc_i[BTB_IDX+1:2];
   assign w_id_idx = id_pc_i[BTB_IDX+1:2];
   assign w_rd_tag = rd_pc_i[XLEN-1:BTB_IDX+2];
   assign w_ex_tag = ex_pc_i[XLEN-1:BTB_IDX+2];
   assign w_id_tag = id_pc_i[XLEN-1:BTB_IDX+2];

   assign w_unused = ^{rd_pc_i[1:0], ex_pc_i[1:0], id_pc_i[1:0]};

   // No write bypass: a same-cycle write is seen from the next lookup on
   assign hit_o    = valid_q[w_rd_idx] & (tag_q[w_rd_idx] == w_rd_tag);
   assign target_o = tgt_q[w_rd_idx];

   // An invalidation also occupies the EX port and blocks a colliding ID write
   assign w_ex_clr = ex_clr_i & valid_q[w_ex_idx] & (tag_q[w_ex_idx] == w_ex_tag);
   assign w_ex_act = ex_we_i | w_ex_clr;
   assign w_id_act = id_we_i & ~(w_ex_act & (w_id_idx == w_ex_idx));

   always_comb begin
      valid_d = valid_q;
      if (w_id_act) begin
         valid_d[w_id_idx] = 1'b1;
      end
      if (ex_we_i) begin
         valid_d[w_ex_idx] = 1'b1;
      end else if (w_ex_clr) begin
         valid_d[w_ex_idx] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and target arrays carry no reset; valid bits gate their use
   always_ff @(posedge clk) begin
      if (w_id_act) begin
         tag_q[w_id_idx] <= w_id_tag;
         tgt_q[w_id_idx] <= id_target_i;
      end
      if (ex_we_i) begin
         tag_q[w_ex_idx] <= w_ex_tag;
         tgt_q[w_ex_idx] <= ex_target_i;
      end
   end

endmodule : btb_dm

`default_nettype wire

// File: rtl/pc_gen_btb.sv
// ============================================================================
// Module : pc_gen_btb
// Brief  : Registered IF-stage PC generator with ID/EX redirect resolution
//          and an optional BTB, enabled by defining PC_GEN_BTB_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_gen_btb
   import pipe_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
   parameter int unsigned     BTB_IDX  = 3,
   parameter int unsigned     PC_INC   = PC_INC_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_if,
   output logic [XLEN-1:0] pc_if,
   output logic            pred_taken_if,
   input  logic            jal_id,
   input  logic            jalr_id,
   input  logic            pred_taken_id,
   input  logic [XLEN-1:0] pc_id,
   input  logic [XLEN-1:0] imm_id,
   input  logic [XLEN-1:0] rs1_id,
   input  logic            br_valid_ex,
   input  logic            br_taken_ex,
   input  logic            pred_taken_ex,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [XLEN-1:0] imm_ex,
   output logic            flush_if_id,
   output logic            flush_id_ex
);

   localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   npc_sel_e        w_sel;
   logic            w_ex_redir;
   logic            w_id_redir;
   logic            w_btb_hit;
   logic [XLEN-1:0] w_btb_tgt;
   logic [XLEN-1:0] w_ex_taken_tgt;
   logic [XLEN-1:0] w_ex_tgt;
   logic [XLEN-1:0] w_jal_tgt;
   logic [XLEN-1:0] w_jalr_sum;
   logic [XLEN-1:0] w_id_tgt;

   assign w_ex_taken_tgt = pc_ex + imm_ex;
   assign w_ex_tgt       = br_taken_ex ? w_ex_taken_tgt : (pc_ex + INC);
   assign w_jal_tgt      = pc_id + imm_id;
   assign w_jalr_sum     = rs1_id + imm_id;
   assign w_id_tgt       = jalr_id ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_jal_tgt;

`ifdef PC_GEN_BTB_EN
   // Only a disagreement with the prediction carried down the pipe redirects
   assign w_ex_redir = br_valid_ex & (br_taken_ex != pred_taken_ex);
   assign w_id_redir = ~w_ex_redir & (jalr_id | (jal_id & ~pred_taken_id));

   btb_dm #(
      .XLEN    (XLEN),
      .BTB_IDX (BTB_IDX)
   ) u_btb (
      .clk         (clk),
      .rst         (rst),
      .rd_pc_i     (pc_q),
      .hit_o       (w_btb_hit),
      .target_o    (w_btb_tgt),
      .ex_we_i     (br_valid_ex & br_taken_ex),
      .ex_clr_i    (br_valid_ex & ~br_taken_ex),
      .ex_pc_i     (pc_ex),
      .ex_target_i (w_ex_taken_tgt),
      .id_we_i     (jal_id & ~w_ex_redir),
      .id_pc_i     (pc_id),
      .id_target_i (w_jal_tgt)
   );
`else
   // Without a predictor everything is predicted not-taken
   logic w_unused;

   assign w_ex_redir = br_valid_ex & br_taken_ex;
   assign w_id_redir = ~w_ex_redir & (jalr_id | jal_id);
   assign w_btb_hit  = 1'b0;
   assign w_btb_tgt  = '0;
   assign w_unused   = ^{pred_taken_id, pred_taken_ex, 32'(BTB_IDX)};
`endif

   always_comb begin
      w_sel = SEL_SEQ;
      if (w_ex_redir) begin
         w_sel = SEL_EX;
      end else if (w_id_redir) begin
         w_sel = SEL_ID;
      end else if (stall_if) begin
         w_sel = SEL_HOLD;
      end else if (w_btb_hit) begin
         w_sel = SEL_PRED;
      end
   end

   always_comb begin
      pc_d = pc_q + INC;
      case (w_sel)
         SEL_EX:   pc_d = w_ex_tgt;
         SEL_ID:   pc_d = w_id_tgt;
         SEL_HOLD: pc_d = pc_q;
         SEL_PRED: pc_d = w_btb_tgt;
         default:  pc_d = pc_q + INC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_if         = pc_q;
   assign pred_taken_if = w_btb_hit & ~rst;
   assign flush_if_id   = (w_ex_redir | w_id_redir) & ~rst;
   assign flush_id_ex   = w_ex_redir & ~rst;

endmodule : pc_gen_btb

`default_nettype wire

// File: tb/tb_pc_gen_btb.sv
// ============================================================================
// Module : tb_pc_gen_btb
// Brief  : Scoreboard bench for pc_gen_btb; reference model follows the
//          PC_GEN_BTB_EN build setting.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_gen_btb;

`ifdef PC_GEN_BTB_EN
   localparam bit BTB_EN = 1'b1;
`else
   localparam bit BTB_EN = 1'b0;
`endif

   typedef struct packed {
      logic        stall;
      logic        jal;
      logic        jalr;
      logic        pid;
      logic [31:0] pc_id;
      logic [31:0] imm_id;
      logic [31:0] rs1;
      logic        bv;
      logic        bt;
      logic        bp;
      logic [31:0] pc_ex;
      logic [31:0] imm_ex;
   } stim_t;

   typedef struct packed {
      logic [31:0] npc;
      logic        pred;
      logic        f1;
      logic        f2;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_if = 1'b0;
   logic [31:0] pc_if;
   logic        pred_taken_if;
   logic        jal_id = 1'b0;
   logic        jalr_id = 1'b0;
   logic        pred_taken_id = 1'b0;
   logic [31:0] pc_id = '0;
   logic [31:0] imm_id = '0;
   logic [31:0] rs1_id = '0;
   logic        br_valid_ex = 1'b0;
   logic        br_taken_ex = 1'b0;
   logic        pred_taken_ex = 1'b0;
   logic [31:0] pc_ex = '0;
   logic [31:0] imm_ex = '0;
   logic        flush_if_id;
   logic        flush_id_ex;

   int n_checks = 0;
   int n_errors = 0;

   exp_t sb[$];

   // reference model state
   logic [31:0] m_pc;
   logic        m_v   [8];
   logic [31:0] m_tpc [8];
   logic [31:0] m_tgt [8];

   always #5 clk = ~clk;

   pc_gen_btb #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .BTB_IDX  (3),
      .PC_INC   (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_if      (stall_if),
      .pc_if         (pc_if),
      .pred_taken_if (pred_taken_if),
      .jal_id        (jal_id),
      .jalr_id       (jalr_id),
      .pred_taken_id (pred_taken_id),
      .pc_id         (pc_id),
      .imm_id        (imm_id),
      .rs1_id        (rs1_id),
      .br_valid_ex   (br_valid_ex),
      .br_taken_ex   (br_taken_ex),
      .pred_taken_ex (pred_taken_ex),
      .pc_ex         (pc_ex),
      .imm_ex        (imm_ex),
      .flush_if_id   (flush_if_id),
      .flush_id_ex   (flush_id_ex)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0;
      for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
   endtask

   task automatic model_step(input stim_t s, output exp_t e);
      int   ri, xi, di;
      logic hit, exr, idr, ex_act;
      logic [31:0] np, js;
      ri  = int'(m_pc[4:2]);
      hit = BTB_EN && m_v[ri] && (m_tpc[ri][31:5] == m_pc[31:5]);
      if (BTB_EN) exr = s.bv && (s.bt != s.bp);
      else        exr = s.bv && s.bt;
      idr = !exr && (s.jalr || (s.jal && (!BTB_EN || !s.pid)));
      js  = s.rs1 + s.imm_id;
      if (exr)         np = s.bt ? s.pc_ex + s.imm_ex : s.pc_ex + 32'd4;
      else if (idr)    np = s.jalr ? {js[31:1], 1'b0} : s.pc_id + s.imm_id;
      else if (s.stall) np = m_pc;
      else if (hit)    np = m_tgt[ri];
      else             np = m_pc + 32'd4;
      e.npc  = np;
      e.pred = hit;
      e.f1   = exr | idr;
      e.f2   = exr;
      if (BTB_EN) begin
         xi = int'(s.pc_ex[4:2]);
         di = int'(s.pc_id[4:2]);
         ex_act = 1'b0;
         if (s.bv && s.bt) begin
            m_v[xi] = 1'b1; m_tpc[xi] = s.pc_ex; m_tgt[xi] = s.pc_ex + s.imm_ex;
            ex_act = 1'b1;
         end else if (s.bv && m_v[xi] && (m_tpc[xi][31:5] == s.pc_ex[31:5])) begin
            m_v[xi] = 1'b0;
            ex_act = 1'b1;
         end
         if (s.jal && !exr && !(ex_act && di == xi)) begin
            m_v[di] = 1'b1; m_tpc[di] = s.pc_id; m_tgt[di] = s.pc_id + s.imm_id;
         end
      end
      m_pc = np;
   endtask

   task automatic apply(input stim_t s);
      stall_if      = s.stall;
      jal_id        = s.jal;
      jalr_id       = s.jalr;
      pred_taken_id = s.pid;
      pc_id         = s.pc_id;
      imm_id        = s.imm_id;
      rs1_id        = s.rs1;
      br_valid_ex   = s.bv;
      br_taken_ex   = s.bt;
      pred_taken_ex = s.bp;
      pc_ex         = s.pc_ex;
      imm_ex        = s.imm_ex;
   endtask

   // Drive one cycle shortly after a rising edge; comb outputs sampled mid-cycle
   task automatic cycle(input stim_t s);
      exp_t e, o;
      apply(s);
      model_step(s, e);
      sb.push_back(e);
      #2;
      o = sb.pop_front();
      chk("pred_taken_if", 32'(pred_taken_if), 32'(o.pred));
      chk("flush_if_id", 32'(flush_if_id), 32'(o.f1));
      chk("flush_id_ex", 32'(flush_id_ex), 32'(o.f2));
      @(posedge clk);
      #1;
      chk("pc_if", pc_if, o.npc);
   endtask

   task automatic idle();
      stim_t s;
      s = '0;
      cycle(s);
   endtask

   task automatic jalr_to(input logic [31:0] a);
      stim_t s;
      s = '0;
      s.jalr = 1'b1;
      s.rs1  = a;
      cycle(s);
   endtask

   task automatic ex_br(input logic [31:0] pc, input logic [31:0] imm, input logic t, input logic p);
      stim_t s;
      s = '0;
      s.bv = 1'b1; s.bt = t; s.bp = p; s.pc_ex = pc; s.imm_ex = imm;
      cycle(s);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_pc"}, pc_if, 32'h0);
      chk({tag, "_pred"}, 32'(pred_taken_if), 32'h0);
      chk({tag, "_fl_if_id"}, 32'(flush_if_id), 32'h0);
      chk({tag, "_fl_id_ex"}, 32'(flush_id_ex), 32'h0);
   endtask

   initial begin
      stim_t s;
      model_reset();
      // redirect requests present during reset must not leak onto the flushes
      s = '0;
      s.jal = 1'b1; s.bv = 1'b1; s.bt = 1'b1; s.pc_ex = 32'h40; s.imm_ex = 32'h8;
      apply(s);
      #2;
      check_reset_outputs("por");
      s = '0;
      apply(s);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("por_release_pc", pc_if, 32'h0);

      // sequential run to 0x40, then asynchronous reset mid-cycle
      for (int i = 0; i < 16; i++) idle();
      chk("seq_pc_40", pc_if, 32'h40);
      s = '0;
      s.jal = 1'b1; s.pc_id = 32'h3C; s.imm_id = 32'h100;
      apply(s);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      s = '0;
      apply(s);
      #1;
      rst = 1'b0;
      model_reset();
      chk("midrst_release_pc", pc_if, 32'h0);
      idle();
      chk("seq_pc_4", pc_if, 32'h4);
      idle();
      chk("seq_pc_8", pc_if, 32'h8);

      // taken branch trains the BTB, refetch predicts it
      ex_br(32'h10, 32'h20, 1'b1, 1'b0);
      chk("ex_taken_pc", pc_if, 32'h30);
      jalr_to(32'h10);
      idle();
      if (BTB_EN) chk("btb_predict_pc", pc_if, 32'h30);

      // predicted-taken branch resolves not taken
      ex_br(32'h10, 32'h20, 1'b0, 1'b1);
      jalr_to(32'h10);
      idle();

      // simultaneous EX mispredict and ID jalr: EX wins
      s = '0;
      s.bv = 1'b1; s.bt = 1'b1; s.bp = 1'b0; s.pc_ex = 32'h80; s.imm_ex = 32'h80;
      s.jalr = 1'b1; s.rs1 = 32'h201;
      cycle(s);
      chk("simul_pc", pc_if, 32'h100);

      // stall holds the PC; a jal redirect overrides the stall
      jalr_to(32'h8);
      for (int i = 0; i < 3; i++) begin
         s = '0;
         s.stall = 1'b1;
         cycle(s);
         chk("stall_hold_pc", pc_if, 32'h8);
      end
      s = '0;
      s.stall = 1'b1; s.jal = 1'b1; s.pc_id = 32'h4; s.imm_id = 32'h40;
      cycle(s);
      chk("stall_jal_pc", pc_if, 32'h44);

      // aliasing: 0x30 evicts 0x10 from the same index
      ex_br(32'h10, 32'h20, 1'b1, 1'b0);
      ex_br(32'h30, 32'h20, 1'b1, 1'b0);
      jalr_to(32'h10);
      idle();

      // PC wrap-around
      jalr_to(32'hFFFF_FFFC);
      idle();
      chk("wrap_pc", pc_if, 32'h0);

      // randomised traffic against the model
      for (int n = 0; n < 400; n++) begin
         int r;
         s = '0;
         s.stall = ($urandom_range(0, 5) == 0);
         r = int'($urandom_range(0, 9));
         if (r < 2) begin
            s.jalr   = 1'b1;
            s.rs1    = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 1));
            s.imm_id = 32'($urandom_range(0, 7)) * 4;
         end else if (r < 5) begin
            s.jal    = 1'b1;
            s.pid    = 1'($urandom_range(0, 1));
            s.pc_id  = 32'($urandom_range(0, 31)) * 4;
            s.imm_id = 32'($urandom_range(0, 15)) * 4;
         end
         if ($urandom_range(0, 2) == 0) begin
            s.bv     = 1'b1;
            s.bt     = 1'($urandom_range(0, 1));
            s.bp     = 1'($urandom_range(0, 1));
            s.pc_ex  = 32'($urandom_range(0, 31)) * 4;
            s.imm_ex = 32'($urandom_range(0, 15)) * 4;
         end
         cycle(s);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_pc_gen_btb

`default_nettype wire
